// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width,
// FSM state encoding and the index of the final iteration.
package shift_add_multiplier_pkg;

    localparam int unsigned WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ITER_LAST = 2'd3;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Existing 4-bit ripple-carry adder; the multiplier's only arithmetic resource.
module adder
    import shift_add_multiplier_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    always_comb begin
        logic [WIDTH:0] carry;
        carry    = '0;
        carry[0] = Cin;
        S        = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            S[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
        end
        Cout = carry[WIDTH];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned multiplier: one add and one shift per multiplier
// bit through the shared ripple-carry adder, start/done handshake.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     p_q, p_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 c_q, c_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     sum;
    logic                 cout;

    adder u_adder (
        .A    (p_q),
        .B    (m_q),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            p_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    p_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (q_q[0]) begin
                    {c_d, p_d} = {cout, sum};
                end else begin
                    c_d = 1'b0;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                // Logical right shift of the 9-bit {C,P,Q}; carry is absorbed here.
                c_d = 1'b0;
                p_d = {c_q, p_q[WIDTH-1:1]};
                q_d = {p_q[0], q_q[WIDTH-1:1]};
                if (cnt_q == ITER_LAST) begin
                    product_d = {c_q, p_q, q_q[WIDTH-1:1]};
                    state_d   = DONE;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = ADD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and exhaustive bench for shift_add_multiplier with a queue-based
// scoreboard of expected products popped at every done pulse.
module tb_shift_add_multiplier;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int         tests;
    int         fails;
    logic [7:0] sb[$];
    logic [7:0] prev_prod;

    shift_add_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++)
            if (y[i]) acc = acc + ({4'b0, x} << i);
        return acc;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL done_unexpected: observed done=1 expected empty-queue done=0");
            end
            if (sb.size() != 0) check("product", product, sb.pop_front());
        end
    end

    // Starts one multiply from IDLE with a single-cycle start pulse and
    // checks idle outputs before, plus busy/done timing through E9.
    task automatic do_mul(input logic [3:0] ai, input logic [3:0] bi);
        logic [7:0] e;
        e = ref_mul(ai, bi);
        @(negedge clk);
        check("idle_busy", {7'b0, busy}, 8'd0);
        check("idle_done", {7'b0, done}, 8'd0);
        check("idle_product_hold", product, prev_prod);
        a = ai;
        b = bi;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("busy_k%0d", k), {7'b0, busy}, (k <= 8) ? 8'd1 : 8'd0);
            check($sformatf("done_k%0d", k), {7'b0, done}, (k == 9) ? 8'd1 : 8'd0);
        end
        prev_prod = e;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        prev_prod = 8'h00;
        rst       = 1'b1;
        start     = 1'b1;
        a         = 4'd9;
        b         = 4'd6;

        // Reset held with start high: reset must win.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("reset_busy", {7'b0, busy}, 8'd0);
        check("reset_done", {7'b0, done}, 8'd0);
        check("reset_product", product, 8'h00);

        do_mul(4'd9, 4'd6);
        do_mul(4'd15, 4'd15);
        do_mul(4'd0, 4'd13);
        do_mul(4'd13, 4'd1);

        // start held high: one result every 10 cycles, operands disturbed mid-run.
        @(negedge clk);
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        sb.push_back(ref_mul(4'd3, 4'd5));
        for (int op = 0; op < 3; op++) begin
            @(posedge clk);
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k <= 9) begin
                    check($sformatf("hold_busy_op%0d_k%0d", op, k), {7'b0, busy}, (k <= 8) ? 8'd1 : 8'd0);
                    check($sformatf("hold_done_op%0d_k%0d", op, k), {7'b0, done}, (k == 9) ? 8'd1 : 8'd0);
                end
                if (k == 4) begin
                    a = 4'($urandom);
                    b = 4'($urandom);
                end
                if (k == 10) begin
                    check($sformatf("hold_idle_op%0d", op), {7'b0, busy | done}, 8'd0);
                    if (op < 2) begin
                        a = 4'd3;
                        b = 4'd5;
                        sb.push_back(ref_mul(4'd3, 4'd5));
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        prev_prod = 8'h0F;

        // Abort a 7x7 on its 4th busy cycle.
        @(negedge clk);
        a = 4'd7;
        b = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {7'b0, busy}, 8'd0);
        check("abort_done", {7'b0, done}, 8'd0);
        check("abort_product", product, 8'h00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_stays_idle", {7'b0, busy | done}, 8'd0);
        end
        prev_prod = 8'h00;
        do_mul(4'd7, 4'd7);

        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                do_mul(4'(ai), 4'(bi));

        @(negedge clk);
        check("final_product_hold", product, prev_prod);
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential 4x4 unsigned multiplier that reuses the team's 4-bit ripple-carry `adder` module as its only arithmetic resource. A small FSM sequences one add and one shift per multiplier bit, producing an 8-bit product after a fixed latency. It sits between a requester (start/done handshake) and the shared adder datapath. It is the first step toward time-sharing the adder between multi-cycle operations.

## Interface
- WIDTH, 4, operand width; only 4 is legal because the `adder` instance is fixed at 4 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  in  1  request pulse or level; accepted only in IDLE.
- a  in  4  multiplicand; sampled on the accepting edge.
- b  in  4  multiplier; sampled on the accepting edge.
- busy  out  1  high while in ADD or SHIFT.
- done  out  1  high for exactly one cycle (state DONE).
- product  out  8  result register; valid from the DONE cycle, held until the next accept or reset.

## Operation
- Internal registers:
  - M[3:0]: multiplicand.
  - P[3:0]: upper accumulator.
  - Q[3:0]: multiplier / lower product.
  - C: adder carry-out.
  - cnt[1:0]: iteration count.
  - state[1:0].
- States are IDLE, ADD, SHIFT, DONE.
- IDLE:
  - If start=1: M<=a, Q<=b, P<=0, C<=0, cnt<=0, go to ADD.
  - Otherwise stay in IDLE.
- ADD:
  - If Q[0]=1: {C,P} <= {Cout,S} from `adder`(A=P, B=M, Cin=0).
  - Otherwise C<=0 and P is unchanged.
  - Always go to SHIFT.
- SHIFT:
  - {C,P,Q} <= {1'b0,C,P,Q} >> 1, i.e. logical right shift of the 9-bit {C,P,Q}.
  - If cnt==3: product <= {C,P[3:0],Q[3:1]}, which is the post-shift value {P,Q}; go to DONE.
  - Otherwise cnt<=cnt+1 and go to ADD.
- DONE:
  - done=1.
  - Go to IDLE unconditionally.
  - start is ignored in this cycle.
- start is ignored in ADD, SHIFT and DONE. No queuing; the requester must re-assert after done.
- a and b may change freely after the accepting edge.
- Arithmetic is unsigned. The product is exact for all 256 operand pairs; maximum value is 15x15=225=0xE1.
- The carry from ADD is consumed by the following SHIFT, so no overflow is possible.
- Reset value of every output: busy=0, done=0, product=8'h00. state=IDLE; all internal registers are 0.
- Reset mid-operation aborts the multiply and clears product. It has priority over start in the same edge.

## Timing
- Accepting edge is E0 (IDLE, start=1).
- ADD/SHIFT occupy the cycles after E0 through E8: 4 iterations x 2 cycles.
- The DONE state is entered at E8. done=1 and product is valid in the cycle following E8.
- At E9 the block returns to IDLE. The earliest next accept is E10: start high during the cycle after done.
- Throughput is one multiply per 10 cycles when start is held high continuously.
- busy=1 from the cycle after E0 through the cycle after E7, which is 8 cycles.
- busy and done are never high together.
- The adder path is combinational, single cycle, within one clock period. No multicycle constraint is needed.

## Structure
- The shared package holds:
  - state encoding localparams: IDLE=2'd0, ADD=2'd1, SHIFT=2'd2, DONE=2'd3;
  - WIDTH=4;
  - ITER_LAST=2'd3.
- One sub-module: the existing `adder` (ports A, B, Cin, S, Cout), instantiated once with Cin tied to 0.
- No other hierarchy. The FSM, shift register and counter are in the top-level module.

## Test plan
- Reset, then a=9, b=6, start pulse:
  - busy high 8 cycles;
  - done single cycle 9 edges after accept;
  - product=8'h36 (54).
- a=15, b=15 (carry path every iteration) -> product=8'hE1. Then a=0, b=13 -> product=8'h00. Then a=13, b=1 -> product=8'h0D.
- Hold start=1 continuously with a=3, b=5:
  - done every 10 cycles;
  - product=8'h0F each time;
  - start during busy/done has no effect;
  - changing a/b mid-operation does not alter the result.
- Assert rst for one cycle at the 4th busy cycle of a=7 x b=7:
  - next cycle busy=0, done=0, product=0, state IDLE;
  - a fresh start with a=7, b=7 yields 8'h31.
- Exhaustive sweep of all 256 (a,b) pairs against a reference model. product must equal a*b at every done, and product must stay stable in IDLE between operations.
